// File: rtl/alu4_pkg.sv
// Shared types and constants for the alu4 issue/writeback controller and its register file.
package alu4_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned NREGS   = 4;
    localparam int unsigned AW      = 2;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    // Instruction layout: {op, rd, rs, use_imm, rt_imm}
    localparam int unsigned OP_MSB  = 11;
    localparam int unsigned OP_LSB  = 9;
    localparam int unsigned RD_MSB  = 8;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS_MSB  = 6;
    localparam int unsigned RS_LSB  = 5;
    localparam int unsigned IMM_BIT = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 0;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu4_regfile.sv
// Register file for alu4_issue_ctrl: two operand read ports, a debug read port,
// and a host write port plus an ALU writeback port.
module alu4_regfile
    import alu4_pkg::*;
#(
    parameter int unsigned DATA_W = alu4_pkg::DATA_W,
    parameter int unsigned NREGS  = alu4_pkg::NREGS,
    parameter int unsigned AW     = alu4_pkg::AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              host_we,
    input  logic [AW-1:0]     host_waddr,
    input  logic [DATA_W-1:0] host_wdata
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    assign rdata_a   = mem_q[raddr_a];
    assign rdata_b   = mem_q[raddr_b];
    assign dbg_rdata = mem_q[dbg_raddr];

    // Writeback is applied after the host write so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (host_we) mem_d[host_waddr] = host_wdata;
        if (wb_we)   mem_d[wb_waddr]   = wb_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu4_issue_ctrl.sv
// Issue/writeback controller around an external alu4: IDLE -> EXEC -> DONE, one instruction in flight.
// Optional ALU4_ISSUE_STALL_CNT_EN adds a saturating stall_cnt output counting DONE cycles without out_ready.
module alu4_issue_ctrl
    import alu4_pkg::*;
#(
    parameter int unsigned DATA_W = alu4_pkg::DATA_W,
    parameter int unsigned NREGS  = alu4_pkg::NREGS,
    parameter int unsigned AW     = alu4_pkg::AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [AW-1:0]     out_rd,
    output logic [3:0]        flags,
    input  logic              host_we,
    input  logic [AW-1:0]     host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [AW-1:0]     dbg_raddr,
`ifdef ALU4_ISSUE_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [DATA_W-1:0] dbg_rdata
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [AW-1:0]     out_rd_q, out_rd_d;
    logic [3:0]        flags_q, flags_d;
    logic              wb_we;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    alu4_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .raddr_a    (in_instr[RS_LSB +: AW]),
        .rdata_a    (rs_data),
        .raddr_b    (in_instr[RT_LSB +: AW]),
        .rdata_b    (rt_data),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .wb_we      (wb_we),
        .wb_waddr   (rd_q),
        .wb_wdata   (alu_result),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata)
    );

    assign in_ready   = (state_q == IDLE) && !reset;
    assign out_valid  = (state_q == DONE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign flags      = flags_q;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        flags_d      = flags_q;
        wb_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_a_d  = rs_data;
                    alu_b_d  = in_instr[IMM_BIT] ? in_instr[RT_MSB:RT_LSB] : rt_data;
                    alu_op_d = in_instr[OP_MSB:OP_LSB];
                    rd_d     = in_instr[RD_MSB:RD_LSB];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                wb_we        = 1'b1;
                flags_d      = alu_flags;
                out_result_d = alu_result;
                out_rd_d     = rd_q;
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rd_q         <= '0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            flags_q      <= flags_d;
        end
    end

`ifdef ALU4_ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == DONE) && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
`endif

endmodule
